// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: op codes, ALU control codes,
// P register bit positions, reset value and FSM state encoding.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_ADC   = 3'd0,
    OP_SBC   = 3'd1,
    OP_AND   = 3'd2,
    OP_ORA   = 3'd3,
    OP_EOR   = 3'd4,
    OP_LSR   = 3'd5,
    OP_CMP   = 3'd6,
    OP_ADD16 = 3'd7
  } op_e;

  localparam logic [2:0] ALU_SUM = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SR  = 3'b100;

  localparam int unsigned P_C = 0;
  localparam int unsigned P_Z = 1;
  localparam int unsigned P_I = 2;
  localparam int unsigned P_D = 3;
  localparam int unsigned P_B = 4;
  localparam int unsigned P_U = 5;
  localparam int unsigned P_V = 6;
  localparam int unsigned P_N = 7;

  localparam logic [7:0] P_RESET = 8'h24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS1,
    ST_PASS2,
    ST_DONE
  } state_e;

  function automatic logic two_pass(input op_e op, input logic dec);
    return (op == OP_ADD16) || (dec && (op == OP_ADC || op == OP_SBC));
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between a requester and the ALU sequencer.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [7:0]  req_a_hi;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_y;

  modport master (
    output req_valid, req_op, req_a, req_b, req_a_hi, rsp_ready,
    input  req_ready, rsp_valid, rsp_y
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_a_hi, rsp_ready,
    output req_ready, rsp_valid, rsp_y
  );
endinterface

// File: rtl/alu_sequencer_bcd.sv
// Decimal-mode correction for ADC/SBC: derives the second-pass addend and
// the final carry from the latched operands and the binary first pass.
module bcd_adjust (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c,
  input  logic [7:0] r1,
  input  logic       carry1,
  input  logic       sub,
  output logic [7:0] adj,
  output logic       c_final
);
  logic [4:0] lo_add;
  logic [4:0] hi_add;
  logic [4:0] lo_sub;
  logic       lo_dec;
  logic       hi_dec;
  logic       lo_borrow;

  // r1 is part of the adjust interface; nibble sums are rebuilt from the operands.
  logic unused_r1;
  assign unused_r1 = ^r1;

  always_comb begin
    lo_add    = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, c};
    lo_dec    = lo_add > 5'd9;
    hi_add    = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0000, lo_dec};
    hi_dec    = hi_add > 5'd9;
    lo_sub    = {1'b0, a[3:0]} + {1'b0, ~b[3:0]} + {4'b0000, c};
    lo_borrow = ~lo_sub[4];
    adj       = '0;
    c_final   = carry1;
    if (sub) begin
      adj = (lo_borrow ? 8'hFA : 8'h00) + (carry1 ? 8'h00 : 8'hA0);
    end else begin
      adj     = {(hi_dec ? 4'h6 : 4'h0), (lo_dec ? 4'h6 : 4'h0)};
      c_final = carry1 | hi_dec;
    end
  end
endmodule

// File: rtl/alu_sequencer.sv
// Sequences 8-bit ALU operations (with decimal adjust and 16-bit address add)
// over one or two passes through an external ALU and maintains the P register.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus,
  input  logic            p_wr_en,
  input  logic [7:0]      p_wr_data,
  output logic [7:0]      p_out,
  output logic [2:0]      alu_ctrl,
  output logic [7:0]      alu_AI,
  output logic [7:0]      alu_BI,
  output logic            alu_carry,
  output logic            alu_BCD,
  input  logic [7:0]      alu_Y,
  input  logic [7:0]      alu_flags
);
  state_e      state_q, state_d;
  op_e         op_q;
  logic [7:0]  a_q, b_q, ahi_q, r1_q, p_q, p_upd, p_wr_val, bop, bcd_adj;
  logic        c_q, d_q, carry1_q, v1_q, v_now, bcd_c, accept, finish;
  logic [15:0] rsp_y_q, result;

  logic unused_flags;
  assign unused_flags = ^alu_flags[7:1];

  assign accept        = bus.req_valid && (state_q == ST_IDLE);
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_DONE);
  assign bus.rsp_y     = rsp_y_q;
  assign p_out         = p_q;
  assign alu_BCD       = 1'b0;
  assign finish        = (state_q == ST_PASS2) ||
                         (state_q == ST_PASS1 && !two_pass(op_q, d_q));

  bcd_adjust u_bcd (
    .a       (a_q),
    .b       (b_q),
    .c       (c_q),
    .r1      (r1_q),
    .carry1  (carry1_q),
    .sub     (op_q == OP_SBC),
    .adj     (bcd_adj),
    .c_final (bcd_c)
  );

  always_comb begin
    state_d   = state_q;
    alu_ctrl  = ALU_SUM;
    alu_AI    = '0;
    alu_BI    = '0;
    alu_carry = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_PASS1;
      ST_PASS1: begin
        state_d = two_pass(op_q, d_q) ? ST_PASS2 : ST_DONE;
        alu_AI  = a_q;
        case (op_q)
          OP_ADC:   begin alu_BI = b_q;  alu_carry = c_q;  end
          OP_SBC:   begin alu_BI = ~b_q; alu_carry = c_q;  end
          OP_CMP:   begin alu_BI = ~b_q; alu_carry = 1'b1; end
          OP_AND:   begin alu_ctrl = ALU_AND; alu_BI = b_q; end
          OP_ORA:   begin alu_ctrl = ALU_OR;  alu_BI = b_q; end
          OP_EOR:   begin alu_ctrl = ALU_XOR; alu_BI = b_q; end
          OP_LSR:   alu_ctrl = ALU_SR;
          OP_ADD16: alu_BI = b_q;
        endcase
      end
      ST_PASS2: begin
        state_d = ST_DONE;
        if (op_q == OP_ADD16) begin
          alu_AI    = ahi_q;
          alu_carry = carry1_q;
        end else begin
          alu_AI = r1_q;
          alu_BI = bcd_adj;
        end
      end
      ST_DONE: if (bus.rsp_ready) state_d = ST_IDLE;
    endcase
  end

  // Flags come from whichever pass finishes; V always reflects the binary first pass.
  always_comb begin
    p_wr_val      = p_wr_data;
    p_wr_val[P_U] = 1'b1;
    bop    = (op_q == OP_SBC) ? ~b_q : b_q;
    v_now  = (a_q[7] == bop[7]) && (alu_Y[7] != a_q[7]);
    p_upd  = p_q;
    result = {8'h00, alu_Y};
    case (op_q)
      OP_ADC, OP_SBC: begin
        p_upd[P_N] = alu_Y[7];
        p_upd[P_Z] = (alu_Y == 8'h00);
        p_upd[P_C] = (state_q == ST_PASS2) ? bcd_c : alu_flags[0];
        p_upd[P_V] = (state_q == ST_PASS2) ? v1_q : v_now;
      end
      OP_CMP: begin
        p_upd[P_N] = alu_Y[7];
        p_upd[P_Z] = (alu_Y == 8'h00);
        p_upd[P_C] = alu_flags[0];
        result     = {8'h00, a_q};
      end
      OP_AND, OP_ORA, OP_EOR: begin
        p_upd[P_N] = alu_Y[7];
        p_upd[P_Z] = (alu_Y == 8'h00);
      end
      OP_LSR: begin
        p_upd[P_N] = 1'b0;
        p_upd[P_Z] = (alu_Y == 8'h00);
        p_upd[P_C] = a_q[0];
      end
      OP_ADD16: result = {alu_Y, r1_q};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      p_q      <= P_RESET;
      rsp_y_q  <= '0;
      op_q     <= OP_ADC;
      a_q      <= '0;
      b_q      <= '0;
      ahi_q    <= '0;
      c_q      <= 1'b0;
      d_q      <= 1'b0;
      r1_q     <= '0;
      carry1_q <= 1'b0;
      v1_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && p_wr_en) p_q <= p_wr_val;
      if (accept) begin
        op_q  <= op_e'(bus.req_op);
        a_q   <= bus.req_a;
        b_q   <= bus.req_b;
        ahi_q <= bus.req_a_hi;
        c_q   <= p_wr_en ? p_wr_data[P_C] : p_q[P_C];
        d_q   <= p_wr_en ? p_wr_data[P_D] : p_q[P_D];
      end
      if (state_q == ST_PASS1) begin
        r1_q     <= alu_Y;
        carry1_q <= alu_flags[0];
        v1_q     <= v_now;
      end
      if (finish) begin
        p_q     <= p_upd;
        rsp_y_q <= result;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural external ALU.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       p_wr_en;
  logic [7:0] p_wr_data, p_out, alu_AI, alu_BI, alu_Y, alu_flags;
  logic [2:0] alu_ctrl;
  logic       alu_carry, alu_BCD;
  logic [8:0] alu_sum;

  typedef struct {
    logic [15:0] y;
    logic [7:0]  p;
    int          t;
    int          lat;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer_if bus();

  alu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .p_wr_en   (p_wr_en),
    .p_wr_data (p_wr_data),
    .p_out     (p_out),
    .alu_ctrl  (alu_ctrl),
    .alu_AI    (alu_AI),
    .alu_BI    (alu_BI),
    .alu_carry (alu_carry),
    .alu_BCD   (alu_BCD),
    .alu_Y     (alu_Y),
    .alu_flags (alu_flags)
  );

  always_comb begin
    alu_sum   = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'h00, alu_carry};
    alu_Y     = 8'h00;
    alu_flags = 8'h00;
    case (alu_ctrl)
      3'b000: begin alu_Y = alu_sum[7:0]; alu_flags[0] = alu_sum[8]; end
      3'b001: alu_Y = alu_AI | alu_BI;
      3'b010: alu_Y = alu_AI ^ alu_BI;
      3'b011: alu_Y = alu_AI & alu_BI;
      3'b100: alu_Y = {1'b0, alu_AI[7:1]};
      default: alu_Y = 8'h00;
    endcase
    alu_flags[1] = (alu_Y == 8'h00);
    alu_flags[7] = alu_Y[7];
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid && !seen) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got y=%h with no pending request", bus.rsp_y);
      end else begin
        mon_e = q.pop_front();
        check("rsp_y", bus.rsp_y, mon_e.y);
        check("p_out", 16'(p_out), 16'(mon_e.p));
        check("latency", 16'(cyc - mon_e.t), 16'(mon_e.lat));
      end
    end
    seen = bus.rsp_valid;
  end

  // Returns #1 after the accepting edge, i.e. early in PASS1.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ahi, input logic pw_en, input logic [7:0] pw_data,
                       input logic expect_rsp, input logic [15:0] ey, input logic [7:0] ep,
                       input int lat);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 16'(bus.req_ready), 16'd1);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_a_hi  = ahi;
    bus.req_valid = 1'b1;
    p_wr_en       = pw_en;
    p_wr_data     = pw_data;
    if (expect_rsp) begin
      e.y = ey; e.p = ep; e.t = cyc; e.lat = lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    p_wr_en       = 1'b0;
    bus.req_op    = op ^ 3'd1;
    bus.req_a     = ~a;
    bus.req_b     = ~b;
    bus.req_a_hi  = ~ahi;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || !bus.req_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", 16'(q.size()), 16'd0);
    q.delete();
  endtask

  task automatic pwrite(input logic [7:0] d);
    @(negedge clk);
    p_wr_en   = 1'b1;
    p_wr_data = d;
    @(negedge clk);
    p_wr_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = 3'd0;
    bus.req_a = 8'h00;
    bus.req_b = 8'h00;
    bus.req_a_hi = 8'h00;
    bus.rsp_ready = 1'b1;
    p_wr_en = 1'b0;
    p_wr_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_p_out", 16'(p_out), 16'h0024);
    check("rst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
    check("rst_rsp_y", bus.rsp_y, 16'h0000);
    check("rst_req_ready", 16'(bus.req_ready), 16'd1);
    check("rst_alu_drive", {alu_ctrl, alu_carry, alu_BCD, 11'd0}, 16'h0000);
    check("rst_alu_ops", {alu_AI, alu_BI}, 16'h0000);
    rst = 1'b0;

    // Binary ADC with signed overflow, then ORA zero result.
    issue(OP_ADC, 8'h50, 8'h50, 8'h00, 1'b0, 8'h00, 1'b1, 16'h00A0, 8'hE4, 2);
    wait_drain();
    issue(OP_ORA, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 16'h0000, 8'h66, 2);
    wait_drain();

    // Decimal mode.
    pwrite(8'h28);
    check("pwrite_idle", 16'(p_out), 16'h0028);
    issue(OP_ADC, 8'h58, 8'h46, 8'h00, 1'b0, 8'h00, 1'b1, 16'h0004, 8'h69, 3);
    check("bcd_drive_bcd", 16'(alu_BCD), 16'd0);
    wait_drain();
    issue(OP_SBC, 8'h46, 8'h12, 8'h00, 1'b0, 8'h00, 1'b1, 16'h0034, 8'h29, 3);
    wait_drain();
    issue(OP_SBC, 8'h12, 8'h21, 8'h00, 1'b0, 8'h00, 1'b1, 16'h0091, 8'hA8, 3);
    wait_drain();
    issue(OP_ADC, 8'h09, 8'h09, 8'h00, 1'b0, 8'h00, 1'b1, 16'h0018, 8'h28, 3);
    wait_drain();

    // ADD16 with carry out of the low byte.
    issue(OP_ADD16, 8'hF0, 8'h20, 8'h12, 1'b0, 8'h00, 1'b1, 16'h1310, 8'h28, 3);
    check("add16_p1_ops", {alu_AI, alu_BI}, 16'hF020);
    @(posedge clk);
    #1;
    check("add16_p2_ops", {alu_AI, alu_BI}, 16'h1200);
    check("add16_p2_carry", 16'(alu_carry), 16'd1);
    wait_drain();

    // CMP equal with response back-pressure.
    pwrite(8'h24);
    bus.rsp_ready = 1'b0;
    issue(OP_CMP, 8'h10, 8'h10, 8'h00, 1'b0, 8'h00, 1'b1, 16'h0010, 8'h27, 2);
    for (int n = 0; n < 10 && !bus.rsp_valid; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 16'(bus.rsp_valid), 16'd1);
      check("hold_ready", 16'(bus.req_ready), 16'd0);
      check("hold_y", bus.rsp_y, 16'h0010);
      check("hold_p", 16'(p_out), 16'h0027);
    end
    bus.rsp_ready = 1'b1;
    wait_drain();

    issue(OP_CMP, 8'h05, 8'h10, 8'h00, 1'b0, 8'h00, 1'b1, 16'h0005, 8'hA4, 2);
    wait_drain();
    issue(OP_AND, 8'hF0, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b1, 16'h0030, 8'h24, 2);
    wait_drain();
    issue(OP_EOR, 8'hFF, 8'h0F, 8'h00, 1'b0, 8'h00, 1'b1, 16'h00F0, 8'hA4, 2);
    wait_drain();
    issue(OP_LSR, 8'h81, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 16'h0040, 8'h25, 2);
    wait_drain();
    issue(OP_LSR, 8'h01, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 16'h0000, 8'h27, 2);
    wait_drain();
    issue(OP_ADC, 8'h7F, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 16'h0081, 8'hE4, 2);
    wait_drain();

    // P write forwarded into the accepted request; a write during PASS1 is dropped.
    issue(OP_ADC, 8'h01, 8'h01, 8'h00, 1'b1, 8'h25, 1'b1, 16'h0003, 8'h24, 2);
    p_wr_en   = 1'b1;
    p_wr_data = 8'hFF;
    @(posedge clk);
    #1;
    p_wr_en   = 1'b0;
    wait_drain();

    // Reset during PASS2 of a decimal ADC abandons it.
    pwrite(8'h28);
    issue(OP_ADC, 8'h58, 8'h46, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_p_out", 16'(p_out), 16'h0024);
    check("midrst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
    check("midrst_req_ready", 16'(bus.req_ready), 16'd1);
    check("midrst_rsp_y", bus.rsp_y, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
    issue(OP_ADC, 8'h01, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 16'h0002, 8'h24, 2);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
